trace_player: RTL
=================

Name: trace_player

Overview:
- Generates a reference spell trace on the 5x5 wand grid, the producing end of the trace interface.
- Steps through a stored ordered list of grid cells for a selected spell and emits one cell index per handshake.
- Accumulates the 25-bit trace bitmap (bit i = cell i visited) alongside the cell stream.
- Drives the order checker and the hint/demo display: shows the player the correct stroke order.

Parameters:
- STEP_GAP, 2, idle cycles inserted between an accepted cell and presentation of the next cell (0 = back-to-back).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin playback of pattern_sel; sampled only in IDLE.
- abort  input  1  synchronous cancel of playback.
- pattern_sel  input  2  spell pattern index, latched on accepted start.
- cell_ready  input  1  consumer accepts cell this cycle.
- cell_valid  output  1  cell_idx/row/col valid.
- cell_idx  output  5  grid cell 0..24, idx = 5*row + col.
- row  output  3  cell_idx / 5.
- col  output  3  cell_idx % 5.
- step_num  output  5  ordinal of the cell currently presented (0-based).
- trace  output  25  bitmap of cells accepted so far.
- busy  output  1  playback in progress.
- done  output  1  one-cycle pulse after the last cell is accepted.

Behaviour:
- Reset (reset_n low, async): state IDLE; all outputs 0; internal gap counter, step and latched selection 0. Reset takes effect immediately mid-playback.
- Pattern ROM (cells in order, length):
  - P0 horizontal: 10,11,12,13,14 (len 5).
  - P1 vertical: 2,7,12,17,22 (len 5).
  - P2 diagonal: 0,6,12,18,24 (len 5).
  - P3 Z: 0,1,2,3,4,8,12,16,20,21,22,23,24 (len 13).
- States: IDLE, EMIT, GAP, DONE.
- IDLE:
  - busy=0, cell_valid=0.
  - On an edge with start=1 (and abort=0): latch pattern_sel, clear trace to 0, step=0, busy=1, go to EMIT.
  - Consequence: cell_valid is high the cycle after start.
- EMIT:
  - cell_valid=1; cell_idx/row/col/step_num reflect ROM[sel][step] and are held stable until accepted.
  - An edge with cell_ready=1 accepts the cell: trace |= 1<<cell_idx.
  - If step == len-1: go to DONE.
  - Otherwise step+1, then go to GAP with counter=STEP_GAP, or directly to EMIT if STEP_GAP=0.
- GAP:
  - cell_valid=0; counter decrements each cycle.
  - Transition to EMIT on the edge where counter==1, giving exactly STEP_GAP invalid cycles.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - trace holds its final value until the next accepted start.
- Valid/ready rules:
  - cell_valid never drops in EMIT without acceptance.
  - cell_ready while cell_valid=0 is ignored.
- start while busy: ignored, with no relatch of pattern_sel.
- start and abort both high in IDLE: abort wins, no start.
- abort:
  - From EMIT or GAP, go to IDLE next edge. busy=0 and cell_valid=0 next cycle.
  - No done pulse; trace retains the partial bitmap; cell_idx/row/col/step_num hold their last values.
  - Abort on the same edge as an accepting cell_ready: the acceptance is not recorded in trace.
- Output timing: all outputs registered; no combinational path from inputs to outputs.
- step_num widths: 5 bits, never exceeds 12.

Test Plan:
- Reset, then P2, STEP_GAP=2, cell_ready tied 1, start pulse at edge 0:
  - cell_valid in cycles 1,4,7,10,13 with cell_idx 0,6,12,18,24 and (row,col) = (0,0),(1,1),(2,2),(3,3),(4,4).
  - done in cycle 14; final trace = 0x1041041.
- P3, STEP_GAP=0, cell_ready=1:
  - 13 consecutive valid cycles, sequence 0,1,2,3,4,8,12,16,20,21,22,23,24, step_num 0..12.
  - Final trace = 0x1F1111F; done once.
- P1 with cell_ready low for 4 cycles on the second cell:
  - cell_idx=7 held stable with cell_valid high throughout; trace stays 0x4 until acceptance.
  - Final trace = 0x421084.
- P0, abort asserted while the third cell (12) is presented with cell_ready=1:
  - Next cycle busy=0, cell_valid=0, no done; trace=0xC00 (cells 10,11 only).
  - A new start of P0 then yields final trace 0x7C00.
- Start re-pulsed with pattern_sel=3 mid-P0 playback → ignored; P0 sequence completes unchanged.
- reset_n dropped asynchronously mid-GAP → outputs 0 immediately without a clock edge; after release, the block stays in IDLE until start.

Source files
------------

// File: rtl/trace_player_if.sv
// Cell stream from the trace player to the order checker and hint display.
// Carries one grid cell per valid/ready handshake plus the running visit bitmap.
// The producer holds every payload field stable while valid is high and not accepted.
interface trace_player_if;
    logic        cell_valid;
    logic        cell_ready;
    logic [4:0]  cell_idx;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [4:0]  step_num;
    logic [24:0] trace;

    modport master (
        output cell_valid, cell_idx, row, col, step_num, trace,
        input  cell_ready
    );

    modport slave (
        input  cell_valid, cell_idx, row, col, step_num, trace,
        output cell_ready
    );
endinterface

// File: rtl/trace_player.sv
// Plays back a stored spell stroke order on the 5x5 grid, one cell per handshake.
// Latency: first cell valid the cycle after start; STEP_GAP idle cycles between cells.
// Backpressure: a presented cell is held until cell_ready; abort cancels without a done pulse.
module trace_player #(
    parameter int STEP_GAP = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            pattern_sel,
    trace_player_if.master        tp,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP, S_DONE} state_t;

    localparam int GW = (STEP_GAP < 2) ? 1 : $clog2(STEP_GAP + 1);

    // Spell patterns: cell index for each step of each pattern.
    function automatic logic [4:0] rom_cell(input logic [1:0] sel, input logic [3:0] step);
        logic [4:0] c;
        c = 5'd0;
        case (sel)
            2'd0: c = (step > 4'd4) ? 5'd0 : 5'd10 + {1'b0, step};
            2'd1: case (step)
                      4'd0: c = 5'd2;   4'd1: c = 5'd7;   4'd2: c = 5'd12;
                      4'd3: c = 5'd17;  4'd4: c = 5'd22;  default: c = 5'd0;
                  endcase
            2'd2: case (step)
                      4'd0: c = 5'd0;   4'd1: c = 5'd6;   4'd2: c = 5'd12;
                      4'd3: c = 5'd18;  4'd4: c = 5'd24;  default: c = 5'd0;
                  endcase
            default: case (step)
                      4'd0: c = 5'd0;   4'd1: c = 5'd1;   4'd2: c = 5'd2;
                      4'd3: c = 5'd3;   4'd4: c = 5'd4;   4'd5: c = 5'd8;
                      4'd6: c = 5'd12;  4'd7: c = 5'd16;  4'd8: c = 5'd20;
                      4'd9: c = 5'd21;  4'd10: c = 5'd22; 4'd11: c = 5'd23;
                      4'd12: c = 5'd24; default: c = 5'd0;
                  endcase
        endcase
        return c;
    endfunction

    function automatic logic [3:0] last_step(input logic [1:0] sel);
        return (sel == 2'd3) ? 4'd12 : 4'd4;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  step_q, step_d;
    logic [GW-1:0] gap_q, gap_d;
    logic        cell_valid_q, cell_valid_d;
    logic [4:0]  cell_idx_q, cell_idx_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic [4:0]  step_num_q, step_num_d;
    logic [24:0] trace_q, trace_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  pres_cell;
    logic [3:0]  pres_step;
    logic [1:0]  pres_sel;
    logic        present;

    // Next-state and next-output logic; payload fields only change when a new cell is presented.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        step_d       = step_q;
        gap_d        = gap_q;
        cell_valid_d = cell_valid_q;
        trace_d      = trace_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        present      = 1'b0;
        pres_sel     = sel_q;
        pres_step    = step_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    sel_d        = pattern_sel;
                    step_d       = 4'd0;
                    trace_d      = 25'd0;
                    busy_d       = 1'b1;
                    cell_valid_d = 1'b1;
                    state_d      = S_EMIT;
                    present      = 1'b1;
                    pres_sel     = pattern_sel;
                    pres_step    = 4'd0;
                end
            end
            S_EMIT: begin
                if (abort) begin
                    busy_d       = 1'b0;
                    cell_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (tp.cell_ready) begin
                    trace_d = trace_q | (25'd1 << cell_idx_q);
                    if (step_q == last_step(sel_q)) begin
                        busy_d       = 1'b0;
                        cell_valid_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        step_d = step_q + 4'd1;
                        if (STEP_GAP == 0) begin
                            present   = 1'b1;
                            pres_step = step_q + 4'd1;
                        end else begin
                            cell_valid_d = 1'b0;
                            gap_d        = GW'(STEP_GAP);
                            state_d      = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (gap_q == GW'(1)) begin
                    cell_valid_d = 1'b1;
                    state_d      = S_EMIT;
                    present      = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pres_cell = rom_cell(pres_sel, pres_step);
        if (present) begin
            cell_idx_d = pres_cell;
            row_d      = 3'(pres_cell / 5'd5);
            col_d      = 3'(pres_cell % 5'd5);
            step_num_d = {1'b0, pres_step};
        end else begin
            cell_idx_d = cell_idx_q;
            row_d      = row_q;
            col_d      = col_q;
            step_num_d = step_num_q;
        end
    end

    // State and registered outputs, cleared immediately on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sel_q        <= 2'd0;
            step_q       <= 4'd0;
            gap_q        <= '0;
            cell_valid_q <= 1'b0;
            cell_idx_q   <= 5'd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            step_num_q   <= 5'd0;
            trace_q      <= 25'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            cell_valid_q <= cell_valid_d;
            cell_idx_q   <= cell_idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            step_num_q   <= step_num_d;
            trace_q      <= trace_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tp.cell_valid = cell_valid_q;
    assign tp.cell_idx   = cell_idx_q;
    assign tp.row        = row_q;
    assign tp.col        = col_q;
    assign tp.step_num   = step_num_q;
    assign tp.trace      = trace_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
